lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//   Leaky integrate-and-fire postsynaptic neuron that sits directly upstream of the STDP timing stage.
//   Each cycle it sums the synaptic weights of the presynaptic inputs that spiked and integrates them into a leaky membrane potential.
//   It emits a one-cycle post_spike pulse on threshold crossing, then enforces a refractory period.
//   Its weight input uses the packed 4x4-bit layout produced by the STDP stage, and post_spike feeds that stage's postsynaptic timer.
// PARAMETERS
//   NUM_PRE     4   number of presynaptic inputs
//   W_WIDTH     4   bits per synaptic weight (unsigned)
//   V_WIDTH     8   membrane potential width (unsigned)
//   THRESHOLD   40  fire when integrated potential >= THRESHOLD
//   LEAK        1   constant subtracted from potential every integrate cycle
//   REFRACTORY  4   cycles inputs are ignored after a spike (0 = none)
// PORTS
//   clk          in   1                  clock
//   rst          in   1                  synchronous reset, active-high
//   pre_spike    in   NUM_PRE            presynaptic spike flags, sampled every clk edge
//   weight       in   NUM_PRE*W_WIDTH    packed weights; input i at weight[(NUM_PRE-i)*W_WIDTH-1 -: W_WIDTH] (input 0 in MSBs)
//   post_spike   out  1                  registered one-cycle fire pulse
//   membrane     out  V_WIDTH            current membrane potential (registered)
//   refractory   out  1                  high while in REFRACT state
//   spike_count  out  8                  total spikes fired, wraps 255->0
// BEHAVIOUR
//   Interface: one clock, clk. Reset is synchronous and active-high.
//   Reset: state=INTEGRATE, membrane=0, refr counter=0, post_spike=0, refractory=0, spike_count=0.
//     Reset takes priority in any state, including mid-refractory; the next state is INTEGRATE.
//   States: INTEGRATE, REFRACT (2-state FSM, registered).
//   INTEGRATE, each edge:
//     sum      = sum over i of (pre_spike[i] ? w_i : 0); width W_WIDTH+clog2(NUM_PRE)+1, no overflow.
//     v_leak   = (membrane > LEAK) ? membrane-LEAK : 0. Leak is applied before the add; no underflow.
//     v_next   = min(v_leak + sum, 2^V_WIDTH-1), saturating.
//     If v_next >= THRESHOLD:
//       post_spike<=1, membrane<=0, spike_count<=spike_count+1.
//       If REFRACTORY>0: state<=REFRACT, counter<=REFRACTORY. Otherwise stay in INTEGRATE.
//     Else: post_spike<=0, membrane<=v_next.
//   REFRACT, each edge:
//     pre_spike and weight are ignored; membrane held at 0; post_spike<=0.
//     counter<=counter-1. When counter==1, state<=INTEGRATE.
//     REFRACT therefore lasts exactly REFRACTORY edges.
//   refractory = (state==REFRACT).
//   Latency: post_spike is high in the cycle after the edge at which the crossing was evaluated.
//     It is high for exactly 1 cycle; back-to-back pulses are possible only when REFRACTORY=0.
//   Weights are sampled combinationally at the edge. Weight changes take effect immediately and are not retimed.
//   Simultaneous spikes on all inputs are summed in a single cycle; no input arbitration.
// TESTING (defaults: THRESHOLD=40, LEAK=1, REFRACTORY=4)
//   1 Reset: rst=1 for 2 edges with random inputs -> all outputs 0, refractory=0.
//   2 Integrate: weight=16'hF000, pre_spike=4'b0001 each edge -> membrane 15, 29, then spike.
//     post_spike=1 after the 3rd edge, membrane=0, spike_count=1.
//   3 Coincidence: weight=16'hFFFF, pre_spike=4'b1111 for one edge -> sum 60, post_spike=1 after the 1st edge.
//   4 Refractory: after test 3, hold pre_spike=4'b1111 -> refractory=1 and membrane=0 for 4 edges, no spike.
//     At the 5th edge the neuron integrates and fires again.
//   5 Leak: pump membrane to 15, then pre_spike=0 -> membrane 14, 13, ..., 0.
//     It then stays at 0 for 5+ more edges with no wrap.
//   6 Reset mid-refractory: assert rst during the 2nd REFRACT cycle.
//     Next cycle: refractory=0, membrane=0, spike_count=0. The next input integrates normally.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: sums spiking synapse weights into a
// leaky membrane, fires a 1-cycle post_spike, then goes refractory.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pre_spike    presynaptic spike flags (one per input)
//   weight       packed weights, input 0 in the MSBs
//   post_spike   registered one-cycle fire pulse
//   membrane     registered membrane potential
//   refractory   high while in REFRACT
//   spike_count  wrapping count of fired spikes
module lif_neuron #(
  parameter int unsigned NUM_PRE    = 4,
  parameter int unsigned W_WIDTH    = 4,
  parameter int unsigned V_WIDTH    = 8,
  parameter int unsigned THRESHOLD  = 40,
  parameter int unsigned LEAK       = 1,
  parameter int unsigned REFRACTORY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  localparam int SUM_W = W_WIDTH + $clog2(NUM_PRE) + 1;
  localparam int ACC_W = V_WIDTH + SUM_W;
  localparam int C_W   =
    (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  localparam logic [V_WIDTH-1:0] THR_V  = V_WIDTH'(THRESHOLD);
  localparam logic [V_WIDTH-1:0] LEAK_V = V_WIDTH'(LEAK);
  localparam logic [C_W-1:0]     REF_C  = C_W'(REFRACTORY);
  localparam logic [ACC_W-1:0]   V_MAX  =
    {{SUM_W{1'b0}}, {V_WIDTH{1'b1}}};

  typedef enum logic {
    S_INT,
    S_REF
  } state_t;

  state_t             state, state_d;
  logic [C_W-1:0]     cnt, cnt_d;
  logic [V_WIDTH-1:0] mem_d;
  logic               post_d;
  logic [7:0]         sc_d;

  logic [SUM_W-1:0]   sum;
  logic [V_WIDTH-1:0] v_leak;
  logic [ACC_W-1:0]   acc;
  logic [V_WIDTH-1:0] v_next;
  logic               fire;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i]) begin
        sum = sum + SUM_W'(
          weight[(NUM_PRE-i)*W_WIDTH-1 -: W_WIDTH]);
      end
    end
  end

  // Leak first (floored at 0), then add and saturate.
  always_comb begin
    v_leak = (membrane > LEAK_V) ? membrane - LEAK_V : '0;
    acc    = ACC_W'(v_leak) + ACC_W'(sum);
    v_next = (acc > V_MAX) ? '1 : acc[V_WIDTH-1:0];
    fire   = (state == S_INT) && (v_next >= THR_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INT;
      cnt         <= '0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      spike_count <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      membrane    <= mem_d;
      post_spike  <= post_d;
      spike_count <= sc_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_INT: begin
        if (fire && (REFRACTORY != 0)) begin
          state_d = S_REF;
        end
      end
      S_REF: begin
        if (cnt == C_W'(1)) begin
          state_d = S_INT;
        end
      end
      default: state_d = S_INT;
    endcase
  end

  always_comb begin
    mem_d  = membrane;
    post_d = 1'b0;
    cnt_d  = cnt;
    sc_d   = spike_count;
    unique case (state)
      S_INT: begin
        if (fire) begin
          mem_d  = '0;
          post_d = 1'b1;
          sc_d   = spike_count + 8'd1;
          cnt_d  = REF_C;
        end else begin
          mem_d = v_next;
        end
      end
      S_REF: begin
        mem_d = '0;
        cnt_d = cnt - C_W'(1);
      end
      default: mem_d = '0;
    endcase
  end

  assign refractory = (state == S_REF);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with default parameters.
// Checks reset, integration, coincidence, refractory, leak, reset.
module tb_lif_neuron;

  logic        clk;
  logic        rst;
  logic [3:0]  pre_spike;
  logic [15:0] weight;
  logic        post_spike;
  logic [7:0]  membrane;
  logic        refractory;
  logic [7:0]  spike_count;

  int passed = 0;
  int total  = 0;

  lif_neuron dut (
    .clk         (clk),
    .rst         (rst),
    .pre_spike   (pre_spike),
    .weight      (weight),
    .post_spike  (post_spike),
    .membrane    (membrane),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] p,
                         input logic [31:0] m,
                         input logic [31:0] r,
                         input logic [31:0] s);
    chk({tag, ".post"}, 32'(post_spike), p);
    chk({tag, ".mem"}, 32'(membrane), m);
    chk({tag, ".refr"}, 32'(refractory), r);
    chk({tag, ".cnt"}, 32'(spike_count), s);
  endtask

  initial begin
    rst       = 1'b1;
    pre_spike = 4'($urandom);
    weight    = 16'($urandom);
    tick();
    pre_spike = 4'($urandom);
    weight    = 16'($urandom);
    tick();
    chk_all("reset", 0, 0, 0, 0);

    // integrate 15 per edge: 15, 29, 28+15=43 -> fire
    rst       = 1'b0;
    weight    = 16'hF000;
    pre_spike = 4'b0001;
    tick();
    chk_all("int1", 0, 15, 0, 0);
    tick();
    chk_all("int2", 0, 29, 0, 0);
    tick();
    chk_all("int3", 1, 0, 1, 1);

    // ride out refractory with inputs active
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("ref_a", 0, 0, (k < 4) ? 1 : 0, 1);
    end

    // coincidence: 4*15 = 60 in one edge
    weight    = 16'hFFFF;
    pre_spike = 4'b1111;
    tick();
    chk_all("coin", 1, 0, 1, 2);

    // refractory with all inputs held active
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("ref_b", 0, 0, (k < 4) ? 1 : 0, 2);
    end
    tick();
    chk_all("refire", 1, 0, 1, 3);

    // drain refractory quietly, then leak test
    pre_spike = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("ref_c", 0, 0, (k < 4) ? 1 : 0, 3);
    end
    weight    = 16'hF000;
    pre_spike = 4'b0001;
    tick();
    chk_all("pump", 0, 15, 0, 3);
    pre_spike = 4'b0000;
    for (int v = 14; v >= 0; v--) begin
      tick();
      chk("leak.mem", 32'(membrane), 32'(v));
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all("floor", 0, 0, 0, 3);
    end

    // reset in the 2nd refractory cycle
    weight    = 16'hFFFF;
    pre_spike = 4'b1111;
    tick();
    chk_all("fire4", 1, 0, 1, 4);
    tick();
    chk_all("ref1", 0, 0, 1, 4);
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 0, 0, 0, 0);
    rst       = 1'b0;
    weight    = 16'hF000;
    pre_spike = 4'b0001;
    tick();
    chk_all("post_rst", 0, 15, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
